// File: rtl/gtfmac_wrapper_syncer_filter.sv
// Multi-bit level synchroniser with per-bit stability filter, glitch flag and
// optional change-event pulses (rise/fall), enabled by GTFMAC_SYNCER_EDGE_PULSE_EN.
// Each bit runs through STAGES sync flops, then must hold a new level for
// FILTER_CYCLES consecutive cycles before dataout follows it.
module gtfmac_wrapper_syncer_filter #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter logic        RESET_VALUE   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] glitch
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    // Reject out-of-range configurations at elaboration
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gtfmac_wrapper_syncer_filter: STAGES must be 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 1024) begin : g_bad_filter
        $error("gtfmac_wrapper_syncer_filter: FILTER_CYCLES must be 1..1024");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0]             synced;
    logic [WIDTH-1:0]             dout_q, dout_d;
    logic [WIDTH-1:0]             glitch_q, glitch_d;
    logic [WIDTH-1:0][CW-1:0]     cnt_q, cnt_d;
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
`endif

    assign synced = sync_q[STAGES-1];

    // Synchroniser chain shift
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = datain;
        for (int unsigned k = 1; k < STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Per-bit stability filter: count while synced differs, commit on the last count,
    // flag a glitch when the level returns before qualifying
    always_comb begin
        dout_d   = dout_q;
        glitch_d = '0;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (synced[i] != dout_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    dout_d[i] = synced[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                glitch_d[i] = (cnt_q[i] != '0);
                cnt_d[i]    = '0;
            end
        end
    end

`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
    // Edge events coincide with the first cycle of the new dataout level
    always_comb begin
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= {(STAGES*WIDTH){RESET_VALUE}};
            dout_q   <= {WIDTH{RESET_VALUE}};
            glitch_q <= '0;
            cnt_q    <= '0;
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
            rise_q   <= '0;
            fall_q   <= '0;
`endif
        end else begin
            sync_q   <= sync_d;
            dout_q   <= dout_d;
            glitch_q <= glitch_d;
            cnt_q    <= cnt_d;
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
            rise_q   <= rise_d;
            fall_q   <= fall_d;
`endif
        end
    end

    assign dataout = dout_q;
    assign glitch  = glitch_q;
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
    assign rise    = rise_q;
    assign fall    = fall_q;
`endif

endmodule

// File: tb/tb_gtfmac_wrapper_syncer_filter.sv
// Bench for gtfmac_wrapper_syncer_filter: a legacy instance (STAGES=2, FILTER_CYCLES=1)
// and a filtering instance (STAGES=3, FILTER_CYCLES=8), both WIDTH=4.
module tb_gtfmac_wrapper_syncer_filter;

`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       l_rst, f_rst;
    logic [3:0] l_din, f_din;
    logic [3:0] l_dout, l_gl, l_ri, l_fa;
    logic [3:0] f_dout, f_gl, f_ri, f_fa;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    gtfmac_wrapper_syncer_filter #(
        .WIDTH(4), .STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(1'b0)
    ) u_leg (
        .clk(clk), .reset(l_rst), .datain(l_din), .dataout(l_dout), .glitch(l_gl)
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
        , .rise(l_ri), .fall(l_fa)
`endif
    );

    gtfmac_wrapper_syncer_filter #(
        .WIDTH(4), .STAGES(3), .FILTER_CYCLES(8), .RESET_VALUE(1'b0)
    ) u_flt (
        .clk(clk), .reset(f_rst), .datain(f_din), .dataout(f_dout), .glitch(f_gl)
`ifdef GTFMAC_SYNCER_EDGE_PULSE_EN
        , .rise(f_ri), .fall(f_fa)
`endif
    );

`ifndef GTFMAC_SYNCER_EDGE_PULSE_EN
    assign l_ri = '0;
    assign l_fa = '0;
    assign f_ri = '0;
    assign f_fa = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack {dataout, glitch, rise, fall}; edge fields are zero in the macro-off build
    function automatic logic [15:0] pk(input logic [3:0] d, input logic [3:0] g,
                                       input logic [3:0] r, input logic [3:0] f);
        pk = EDGE ? {d, g, r, f} : {d, g, 8'h00};
    endfunction

    // Inputs set here are stable before the next edge; outputs read here are post-edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e, got;
        l_rst = 1'b0; f_rst = 1'b0; l_din = 4'hF; f_din = 4'h0;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(pk(4'h0, 4'h0, 4'h0, 4'h0));
            exp_q.push_back(pk(4'h0, 4'h0, 4'h0, 4'h0));
            step();
            got = pk(l_dout, l_gl, l_ri, l_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL reset_hold_leg c=%0d got=%h exp=%h", c, got, e); end
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL reset_hold_flt c=%0d got=%h exp=%h", c, got, e); end
        end
        l_rst = 1'b1; f_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(pk((c >= 2) ? 4'hF : 4'h0, 4'h0, (c == 2) ? 4'hF : 4'h0, 4'h0));
            step();
            got = pk(l_dout, l_gl, l_ri, l_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL reset_release c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_legacy_fall();
        logic [15:0] e, got;
        l_din = 4'hA;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(pk((c >= 2) ? 4'hA : 4'hF, 4'h0, 4'h0, (c == 2) ? 4'h5 : 4'h0));
            step();
            got = pk(l_dout, l_gl, l_ri, l_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL legacy_fall c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_legacy_toggle();
        logic [15:0] e, got;
        logic        b;
        for (int c = 0; c < 10; c++) begin
            l_din = {3'b101, 1'(c)};
            b = (c >= 2) ? 1'(c) : 1'b0;
            exp_q.push_back(pk({3'b101, b}, 4'h0,
                               {3'b000, (c >= 3 && (c % 2) == 1)},
                               {3'b000, (c >= 4 && (c % 2) == 0)}));
            step();
            got = pk(l_dout, l_gl, l_ri, l_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL legacy_toggle c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_qualified();
        logic [15:0] e, got;
        f_din = 4'h1;
        for (int c = 0; c < 13; c++) begin
            exp_q.push_back(pk((c >= 10) ? 4'h1 : 4'h0, 4'h0, (c == 10) ? 4'h1 : 4'h0, 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL qualified_rise c=%0d got=%h exp=%h", c, got, e); end
        end
        f_din = 4'h0;
        for (int c = 0; c < 13; c++) begin
            exp_q.push_back(pk((c >= 10) ? 4'h0 : 4'h1, 4'h0, 4'h0, (c == 10) ? 4'h1 : 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL qualified_fall c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] e, got;
        for (int c = 0; c < 12; c++) begin
            f_din = (c < 5) ? 4'h2 : 4'h0;
            exp_q.push_back(pk(4'h0, (c == 8) ? 4'h2 : 4'h0, 4'h0, 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL glitch_5cyc c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] e, got;
        for (int c = 0; c < 21; c++) begin
            f_din = (c < 8) ? 4'h1 : 4'h0;
            exp_q.push_back(pk((c >= 10 && c <= 17) ? 4'h1 : 4'h0, 4'h0,
                               (c == 10) ? 4'h1 : 4'h0, (c == 18) ? 4'h1 : 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL boundary_8cyc c=%0d got=%h exp=%h", c, got, e); end
        end
        for (int c = 0; c < 13; c++) begin
            f_din = (c < 7) ? 4'h1 : 4'h0;
            exp_q.push_back(pk(4'h0, (c == 10) ? 4'h1 : 4'h0, 4'h0, 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL boundary_7cyc c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    task automatic test_reset_pending();
        logic [15:0] e, got;
        f_din = 4'h1;
        for (int c = 0; c < 22; c++) begin
            f_rst = (c == 8) ? 1'b0 : 1'b1;
            exp_q.push_back(pk((c >= 19) ? 4'h1 : 4'h0, 4'h0, (c == 19) ? 4'h1 : 4'h0, 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL reset_pending c=%0d got=%h exp=%h", c, got, e); end
        end
        f_rst = 1'b1;
    endtask

    task automatic test_independence();
        logic [15:0] e, got;
        for (int c = 0; c < 20; c++) begin
            f_din = {1'b1, ((c % 2) == 0 && c <= 14), 2'b00};
            exp_q.push_back(pk((c >= 10) ? 4'h8 : 4'h0,
                               (c >= 4 && (c % 2) == 0 && c <= 18) ? 4'h4 : 4'h0,
                               (c == 10) ? 4'h8 : 4'h0, 4'h0));
            step();
            got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL independence c=%0d got=%h exp=%h", c, got, e); end
        end
    endtask

    // Return the filter instance to idle with datain low, then confirm it settled
    task automatic test_settle();
        logic [15:0] e, got;
        f_din = 4'h0;
        for (int c = 0; c < 20; c++) step();
        exp_q.push_back(pk(4'h0, 4'h0, 4'h0, 4'h0));
        step();
        got = pk(f_dout, f_gl, f_ri, f_fa); e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL settle got=%h exp=%h", got, e); end
    endtask

    initial begin
        l_rst = 1'b0; f_rst = 1'b0; l_din = 4'h0; f_din = 4'h0;
        test_reset();
        test_legacy_fall();
        test_legacy_toggle();
        test_qualified();
        test_glitch();
        test_boundary();
        test_reset_pending();
        test_settle();
        test_independence();
        test_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gtfmac_wrapper_syncer_filter.md
# gtfmac_wrapper_syncer_filter

Parametrised multi-bit level synchroniser with per-bit glitch filter and change-event outputs, for bringing slow asynchronous status levels (GT lock, reset-done, link status, pin-level controls) into a GTFMAC wrapper clock domain. Each bit runs through a configurable-depth synchroniser chain and then a stability filter that only propagates a new level after it has held for a programmable number of cycles. Rejected pulses are flagged. With `STAGES=2, FILTER_CYCLES=1`, latency and output behaviour match the existing two-flop-plus-output-register level syncer.

## Interface
- `WIDTH`, 1: number of independent channels (bits).
- `STAGES`, 2: synchroniser flops per bit; legal range 2..4.
- `FILTER_CYCLES`, 1: consecutive cycles a new synchronised level must hold before `dataout` follows; legal range 1..1024; 1 = no filtering.
- `RESET_VALUE`, 1'b0: reset value of every sync flop and of `dataout`, applied to all bits.
- `clk` in 1: destination clock.
- `reset` in 1: synchronous, active-low reset (sampled on `clk` rising edge; low = reset).
- `datain` in WIDTH: asynchronous level inputs.
- `dataout` out WIDTH: filtered, synchronised levels, registered.
- `glitch` out WIDTH: one-cycle pulse per bit when a pending change is abandoned before qualifying.
- `rise` out WIDTH: one-cycle pulse when `dataout[i]` goes 0→1. Present only with `GTFMAC_SYNCER_EDGE_PULSE_EN`.
- `fall` out WIDTH: one-cycle pulse when `dataout[i]` goes 1→0. Present only with `GTFMAC_SYNCER_EDGE_PULSE_EN`.

## Operation
- Per bit `i`, fully independent; no cross-bit coherency is guaranteed.
- Sync chain `s[0..STAGES-1]`:
  - `s[0] <= datain[i]`, `s[k] <= s[k-1]`.
  - `synced = s[STAGES-1]`.
  - All stages carry ASYNC_REG.
- Filter counter `cnt`, width `$clog2(FILTER_CYCLES+1)`, reset 0.
- Per-bit filter state:
  - IDLE (`synced == dataout`): `cnt <= 0`. No glitch.
  - PENDING (`synced != dataout`):
    - If `cnt == FILTER_CYCLES-1`: `dataout <= synced`, `cnt <= 0`.
    - Else: `cnt <= cnt+1`.
  - Abandon: `synced == dataout` while `cnt != 0`. Then `glitch <= 1` for one cycle and `cnt <= 0`.
- `FILTER_CYCLES=1`: `dataout <= synced` every cycle; `cnt` is constant 0; `glitch` is never asserted.
- `rise`/`fall` are registered on the same edge that updates `dataout`, so they coincide with the first cycle of the new level. They are never both set for one bit.
- Reset low at an edge:
  - All sync flops and `dataout` ← `RESET_VALUE`.
  - `cnt`, `glitch`, `rise`, `fall` ← 0.
  - An in-flight pending change is discarded.
  - No `rise`/`fall` is generated by reset itself, or by leaving reset.
- Reset values: `dataout = {WIDTH{RESET_VALUE}}`; `glitch`/`rise`/`fall` = 0.
- Illegal parameters (`STAGES<2`, `FILTER_CYCLES<1`) stop elaboration via a generate-time `$error`.

## Timing
- Latency: `datain` stable before edge E ⇒ `dataout` changes at edge `E + STAGES + FILTER_CYCLES - 1`. This is `STAGES+FILTER_CYCLES` edges counting E itself; 3 for the defaults.
- Minimum `datain` pulse that passes: `FILTER_CYCLES` cycles, ±1 cycle sampling uncertainty.
- A pulse of `synced` lasting `1..FILTER_CYCLES-1` cycles:
  - `dataout` unchanged.
  - `glitch` pulses at the edge after `synced` returns.
- Toggling every cycle with `FILTER_CYCLES≥2`:
  - `dataout` never changes.
  - `glitch` pulses every other cycle.
- Reverse change on the qualifying edge (`synced` differs with `cnt == FILTER_CYCLES-1`): the update wins; no glitch.
- All outputs are flop-driven; no combinational path from inputs to outputs.

## Configuration
- Macro: `GTFMAC_SYNCER_EDGE_PULSE_EN`.
- Defined:
  - `rise` and `fall` ports and their registers exist, as described above.
- Undefined:
  - `rise` and `fall` ports are absent from the port list and their registers are not built.
  - `dataout`, `glitch` and latency are identical to the defined build.

## Test plan
- **Reset/release, legacy mode:** `WIDTH=4`, `RESET_VALUE=0`, `FILTER_CYCLES=1`. Hold `reset=0` for 3 edges with `datain=4'hF` → `dataout=0`, no `rise`. Release → `dataout=4'hF` exactly 3 edges after first sampling, and `rise=4'hF` for one cycle.
- **Qualified change:** `STAGES=3`, `FILTER_CYCLES=8`. Step `datain[0]` 0→1 before edge E → `dataout[0]=1` at edge `E+10`, `rise[0]` on that edge only, `glitch=0`.
- **Glitch rejection:** `FILTER_CYCLES=8`. 5-cycle high pulse on `datain[1]` → `dataout[1]` stays 0, one `glitch[1]` pulse, `cnt` back at 0.
- **Boundary:** `FILTER_CYCLES=8`, 8-cycle pulse → passes, `dataout` high for 8 cycles, `rise` then `fall`. 7-cycle pulse → rejected with `glitch`.
- **Reset mid-pending:** assert `reset=0` while `cnt=5` → next edge `dataout=RESET_VALUE`, `cnt=0`, no `glitch`/`fall`.
- **Channel independence and macro-off build:** drive bit 2 with a 1-cycle toggle and bit 3 with a clean step → only bit 3 updates. Recompile without the macro → identical `dataout`/`glitch` waveforms.
